// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use hazard
// detection, bubble insertion on stall/flush and a saturating bubble counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IFIDValid,
   input  logic [4:0]        IFIDRs,
   input  logic [4:0]        IFIDRt,
   input  logic [4:0]        IFIDRd,
   input  logic [DATA_W-1:0] IDReadData1,
   input  logic [DATA_W-1:0] IDReadData2,
   input  logic [DATA_W-1:0] IDImm,
   input  logic [8:0]        IDCtrl,
   input  logic              Flush,
   input  logic              Hold,
   output logic              IDEXValid,
   output logic [4:0]        IDEXRs,
   output logic [4:0]        IDEXRt,
   output logic [4:0]        IDEXRd,
   output logic [DATA_W-1:0] IDEXReadData1,
   output logic [DATA_W-1:0] IDEXReadData2,
   output logic [DATA_W-1:0] IDEXImm,
   output logic [8:0]        IDEXCtrl,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic [CNT_W-1:0]  BubbleCount
);

   localparam int MemReadBit = 6;

   logic              valid_q, valid_d;
   logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
   logic [8:0]        ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              loadUse;
   logic              stall;

   // Register 0 is excluded so a load into $zero never costs a cycle.
   assign loadUse = valid_q & ctrl_q[MemReadBit] & IFIDValid & (rt_q != 5'd0) &
                    ((rt_q == IFIDRs) | (rt_q == IFIDRt));

   // A flush squashes the dependent instruction, so it cancels the stall.
   assign stall     = Hold | (loadUse & ~Flush);
   assign PCWrite   = ~stall;
   assign IFIDWrite = ~stall;

   always_comb begin
      valid_d = valid_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      data1_d = data1_q;
      data2_d = data2_q;
      imm_d   = imm_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (!Hold) begin
         if (Flush | loadUse) begin
            valid_d = 1'b0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            ctrl_d  = '0;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            valid_d = IFIDValid;
            rs_d    = IFIDRs;
            rt_d    = IFIDRt;
            rd_d    = IFIDRd;
            data1_d = IDReadData1;
            data2_d = IDReadData2;
            imm_d   = IDImm;
            ctrl_d  = IDCtrl;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         data1_q <= '0;
         data2_q <= '0;
         imm_q   <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign IDEXValid     = valid_q;
   assign IDEXRs        = rs_q;
   assign IDEXRt        = rt_q;
   assign IDEXRd        = rd_q;
   assign IDEXReadData1 = data1_q;
   assign IDEXReadData2 = data2_q;
   assign IDEXImm       = imm_q;
   assign IDEXCtrl      = ctrl_q;
   assign BubbleCount   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the ID/EX register and hazard rules.
module tb_id_ex_stage;

   localparam int StW = 139;
   localparam logic [8:0] CtrlAdd = 9'h102;
   localparam logic [8:0] CtrlLw  = 9'h1C8;

   logic        clk;
   logic        rst_n;
   logic        IFIDValid;
   logic [4:0]  IFIDRs, IFIDRt, IFIDRd;
   logic [31:0] IDReadData1, IDReadData2, IDImm;
   logic [8:0]  IDCtrl;
   logic        Flush, Hold;
   logic        IDEXValid;
   logic [4:0]  IDEXRs, IDEXRt, IDEXRd;
   logic [31:0] IDEXReadData1, IDEXReadData2, IDEXImm;
   logic [8:0]  IDEXCtrl;
   logic        PCWrite, IFIDWrite;
   logic [15:0] BubbleCount;

   logic        s_IDEXValid;
   logic [4:0]  s_IDEXRs, s_IDEXRt, s_IDEXRd;
   logic [31:0] s_IDEXReadData1, s_IDEXReadData2, s_IDEXImm;
   logic [8:0]  s_IDEXCtrl;
   logic        s_PCWrite, s_IFIDWrite;
   logic [1:0]  BubbleCount2;

   int checks;
   int failures;

   // Behavioural model of what the EX stage should currently hold.
   bit          mValid;
   bit [4:0]    mRs, mRt, mRd;
   bit [31:0]   mD1, mD2, mImm;
   bit [8:0]    mCtrl;
   int          mCnt, mCnt2;

   id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .IFIDValid(IFIDValid), .IFIDRs(IFIDRs),
      .IFIDRt(IFIDRt), .IFIDRd(IFIDRd), .IDReadData1(IDReadData1),
      .IDReadData2(IDReadData2), .IDImm(IDImm), .IDCtrl(IDCtrl),
      .Flush(Flush), .Hold(Hold), .IDEXValid(IDEXValid), .IDEXRs(IDEXRs),
      .IDEXRt(IDEXRt), .IDEXRd(IDEXRd), .IDEXReadData1(IDEXReadData1),
      .IDEXReadData2(IDEXReadData2), .IDEXImm(IDEXImm), .IDEXCtrl(IDEXCtrl),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .BubbleCount(BubbleCount)
   );

   id_ex_stage #(.DATA_W(32), .CNT_W(2)) dutSmall (
      .clk(clk), .rst_n(rst_n), .IFIDValid(IFIDValid), .IFIDRs(IFIDRs),
      .IFIDRt(IFIDRt), .IFIDRd(IFIDRd), .IDReadData1(IDReadData1),
      .IDReadData2(IDReadData2), .IDImm(IDImm), .IDCtrl(IDCtrl),
      .Flush(Flush), .Hold(Hold), .IDEXValid(s_IDEXValid), .IDEXRs(s_IDEXRs),
      .IDEXRt(s_IDEXRt), .IDEXRd(s_IDEXRd), .IDEXReadData1(s_IDEXReadData1),
      .IDEXReadData2(s_IDEXReadData2), .IDEXImm(s_IDEXImm), .IDEXCtrl(s_IDEXCtrl),
      .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .BubbleCount(BubbleCount2)
   );

   logic [StW-1:0] dutState;
   assign dutState = {IDEXValid, IDEXRs, IDEXRt, IDEXRd, IDEXReadData1, IDEXReadData2,
                      IDEXImm, IDEXCtrl, BubbleCount, BubbleCount2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [StW-1:0] expState();
      return {mValid, mRs, mRt, mRd, mD1, mD2, mImm, mCtrl, 16'(mCnt), 2'(mCnt2)};
   endfunction

   function automatic bit modelLoadUse();
      return mValid && mCtrl[6] && IFIDValid && (mRt != 0) &&
             ((mRt == IFIDRs) || (mRt == IFIDRt));
   endfunction

   function automatic bit expWrite();
      return !(Hold || (modelLoadUse() && !Flush));
   endfunction

   function automatic void modelReset();
      mValid = 0; mRs = 0; mRt = 0; mRd = 0;
      mD1 = 0; mD2 = 0; mImm = 0; mCtrl = 0;
      mCnt = 0; mCnt2 = 0;
   endfunction

   function automatic void modelBubble();
      mValid = 0; mRs = 0; mRt = 0; mRd = 0;
      mD1 = 0; mD2 = 0; mImm = 0; mCtrl = 0;
      mCnt  = (mCnt  < 65535) ? mCnt + 1  : 65535;
      mCnt2 = (mCnt2 < 3)     ? mCnt2 + 1 : 3;
   endfunction

   task automatic setId(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [8:0] ctrl);
      IFIDValid = v; IFIDRs = rs; IFIDRt = rt; IFIDRd = rd;
      IDReadData1 = a; IDReadData2 = b; IDImm = imm; IDCtrl = ctrl;
      #1;
   endtask

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic tick();
      bit lu;
      lu = modelLoadUse();
      @(posedge clk);
      if (rst_n && !Hold) begin
         if (Flush || lu) begin
            modelBubble();
         end else begin
            mValid = IFIDValid; mRs = IFIDRs; mRt = IFIDRt; mRd = IFIDRd;
            mD1 = IDReadData1; mD2 = IDReadData2; mImm = IDImm; mCtrl = IDCtrl;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Hold = 1'b0; Flush = 1'b0;
      modelReset();
      setId(1, 5'd3, 5'd4, 5'd5, $urandom, $urandom, $urandom, CtrlLw);
      #2;
      checks++;
      if (dutState !== '0) begin
         failures++;
         $display("[TB] FAIL reset_state got=%h want=0", dutState);
      end
      checks++;
      if ({PCWrite, IFIDWrite} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL reset_write got=%b want=11", {PCWrite, IFIDWrite});
      end
      tick();
      checks++;
      if (dutState !== expState()) begin
         failures++;
         $display("[TB] FAIL reset_held got=%h want=%h", dutState, expState());
      end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_normal();
      setId(1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 32'h10, CtrlAdd);
      checks++;
      if ({PCWrite, IFIDWrite} !== {2{expWrite()}}) begin
         failures++;
         $display("[TB] FAIL normal_write got=%b want=%b", {PCWrite, IFIDWrite}, {2{expWrite()}});
      end
      tick();
      checks++;
      if ({IDEXValid, IDEXRs, IDEXRt, IDEXRd, IDEXReadData1, IDEXCtrl} !==
          {1'b1, 5'd1, 5'd2, 5'd3, 32'h5, CtrlAdd}) begin
         failures++;
         $display("[TB] FAIL normal_capture got=%b_%0d_%0d_%0d_%h_%h", IDEXValid, IDEXRs,
                  IDEXRt, IDEXRd, IDEXReadData1, IDEXCtrl);
      end
      checks++;
      if (dutState !== expState()) begin
         failures++;
         $display("[TB] FAIL normal_state got=%h want=%h", dutState, expState());
      end
   endtask

   task automatic test_load_use();
      int startCnt;
      startCnt = mCnt;
      setId(1, 5'd2, 5'd4, 5'd0, 32'h100, 32'h0, 32'h8, CtrlLw);
      tick();
      setId(1, 5'd4, 5'd1, 5'd5, 32'h11, 32'h22, 32'h0, CtrlAdd);
      checks++;
      if ({PCWrite, IFIDWrite} !== 2'b00 || expWrite() !== 1'b0) begin
         failures++;
         $display("[TB] FAIL loaduse_stall got=%b want=00", {PCWrite, IFIDWrite});
      end
      tick();
      checks++;
      if ({IDEXValid, IDEXCtrl, IDEXRt} !== '0 || dutState !== expState()) begin
         failures++;
         $display("[TB] FAIL loaduse_bubble got=%h want=%h", dutState, expState());
      end
      checks++;
      if ({PCWrite, IFIDWrite} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL loaduse_release got=%b want=11", {PCWrite, IFIDWrite});
      end
      tick();
      checks++;
      if ({IDEXValid, IDEXRs, IDEXRd} !== {1'b1, 5'd4, 5'd5} || BubbleCount !== 16'(startCnt + 1)
          || dutState !== expState()) begin
         failures++;
         $display("[TB] FAIL loaduse_capture got=%h want=%h", dutState, expState());
      end
   endtask

   task automatic test_zero_reg();
      int startCnt;
      startCnt = mCnt;
      setId(1, 5'd3, 5'd0, 5'd0, 32'h40, 32'h0, 32'h4, CtrlLw);
      tick();
      setId(1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, CtrlAdd);
      checks++;
      if ({PCWrite, IFIDWrite} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL zero_reg_write got=%b want=11", {PCWrite, IFIDWrite});
      end
      tick();
      checks++;
      if (IDEXRd !== 5'd6 || BubbleCount !== 16'(startCnt) || dutState !== expState()) begin
         failures++;
         $display("[TB] FAIL zero_reg_state got=%h want=%h", dutState, expState());
      end
   endtask

   task automatic test_flush_loaduse();
      int startCnt;
      setId(1, 5'd1, 5'd7, 5'd0, 32'h80, 32'h0, 32'hC, CtrlLw);
      tick();
      startCnt = mCnt;
      Flush = 1'b1;
      setId(1, 5'd7, 5'd7, 5'd8, 32'h1, 32'h2, 32'h3, CtrlAdd);
      checks++;
      if ({PCWrite, IFIDWrite} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL flush_write got=%b want=11", {PCWrite, IFIDWrite});
      end
      tick();
      Flush = 1'b0;
      checks++;
      if (IDEXValid !== 1'b0 || IDEXCtrl !== 9'd0 || BubbleCount !== 16'(startCnt + 1)
          || dutState !== expState()) begin
         failures++;
         $display("[TB] FAIL flush_bubble got=%h want=%h", dutState, expState());
      end
   endtask

   task automatic test_hold();
      logic [StW-1:0] snap;
      setId(1, 5'd9, 5'd10, 5'd11, $urandom, $urandom, $urandom, CtrlAdd);
      tick();
      snap = expState();
      Hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Flush = (i == 1);
         setId(1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
               9'($urandom));
         checks++;
         if ({PCWrite, IFIDWrite} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL hold_write cycle=%0d got=%b want=00", i, {PCWrite, IFIDWrite});
         end
         tick();
         checks++;
         if (dutState !== snap) begin
            failures++;
            $display("[TB] FAIL hold_state cycle=%0d got=%h want=%h", i, dutState, snap);
         end
      end
      Hold = 1'b0;
      Flush = 1'b0;
   endtask

   task automatic test_reset_midstream();
      setId(1, 5'd1, 5'd12, 5'd0, 32'h90, 32'h0, 32'h0, CtrlLw);
      tick();
      setId(1, 5'd12, 5'd3, 5'd13, 32'h5, 32'h6, 32'h7, CtrlAdd);
      checks++;
      if ({PCWrite, IFIDWrite} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL midreset_prestall got=%b want=00", {PCWrite, IFIDWrite});
      end
      #1;
      rst_n = 1'b0;
      modelReset();
      #1;
      checks++;
      if (dutState !== '0 || {PCWrite, IFIDWrite} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL midreset_async got=%h write=%b want=0 write=11", dutState,
                  {PCWrite, IFIDWrite});
      end
      tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_saturation();
      rst_n = 1'b0;
      modelReset();
      #1;
      rst_n = 1'b1;
      Flush = 1'b1;
      setId(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, CtrlAdd);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (dutState !== expState()) begin
            failures++;
            $display("[TB] FAIL sat_step%0d got=%h want=%h", i, dutState, expState());
         end
      end
      Flush = 1'b0;
      checks++;
      if (BubbleCount2 !== 2'd3 || BubbleCount !== 16'd5) begin
         failures++;
         $display("[TB] FAIL sat_final got=%0d/%0d want=3/5", BubbleCount2, BubbleCount);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         Hold  = ($urandom_range(0, 9) == 0);
         Flush = ($urandom_range(0, 9) == 0);
         setId($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
               ($urandom_range(0, 1) != 0) ? CtrlLw : 9'($urandom));
         checks++;
         if ({PCWrite, IFIDWrite} !== {2{expWrite()}}) begin
            failures++;
            $display("[TB] FAIL rand_write cycle=%0d got=%b want=%b", i, {PCWrite, IFIDWrite},
                     {2{expWrite()}});
         end
         tick();
         checks++;
         if (dutState !== expState()) begin
            failures++;
            $display("[TB] FAIL rand_state cycle=%0d got=%h want=%h", i, dutState, expState());
         end
      end
      Hold = 1'b0;
      Flush = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_normal();
      test_load_use();
      test_zero_reg();
      test_flush_loaduse();
      test_hold();
      test_reset_midstream();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
